// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Imported by uart_rx_monitor and uart_rx_fifo.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } uart_rx_state_e;

   localparam int UART_DATA_BITS = 8;

   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted only alongside a pop.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = UART_DATA_BITS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign pop_data = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART 8N1 receiver with FIFO and error flags.
// Define UART_RX_PARITY_EN for 8E1 framing and parity checking.
module uart_rx_monitor
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 115200,
   parameter int DEPTH    = 4
) (
   input  logic       io_clock,
   input  logic       io_reset,
   input  logic       io_rxd,
   output logic       io_rx_valid,
   input  logic       io_rx_ready,
   output logic [7:0] io_rx_payload,
   output logic       io_frameErr,
   output logic       io_parityErr,
   output logic       io_overrun,
   input  logic       io_clearErr
);

   localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
   localparam int CW  = $clog2(CPB);
   localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CPB - 1);

   logic           s1;
   logic           s2;
   logic           prev;
   logic           fall;
   uart_rx_state_e state;
   logic [CW-1:0]  cnt;
   logic [2:0]     idx;
   logic [7:0]     shift;
   logic           at_half;
   logic           at_last;
   logic           push;
   logic           pop;
   logic           full;
   logic           empty;
   logic           frame_err;

   always_ff @(posedge io_clock) begin
      if (!io_reset) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         prev <= 1'b1;
      end else begin
         s1   <= io_rxd;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign fall    = prev && !s2;
   assign at_half = (cnt == HALF);
   assign at_last = (cnt == LAST);

`ifdef UART_RX_PARITY_EN
   localparam uart_rx_state_e AFTER_DATA = PARITY;
   logic perr;
   logic parity_err;

   assign push = (state == STOP) && at_last && s2 && !perr;
   assign io_parityErr = parity_err;
`else
   localparam uart_rx_state_e AFTER_DATA = STOP;

   assign push = (state == STOP) && at_last && s2;
   assign io_parityErr = 1'b0;
`endif

   always_ff @(posedge io_clock) begin
      if (!io_reset) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr       <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         cnt <= cnt + CW'(1);
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (fall) state <= START;
            end
            START: begin
               if (at_half) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= s2 ? IDLE : DATA;
               end
            end
            DATA: begin
               if (at_last) begin
                  cnt        <= '0;
                  shift[idx] <= s2;
                  idx        <= idx + 3'd1;
                  if (idx == 3'd7) state <= AFTER_DATA;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (at_last) begin
                  cnt   <= '0;
                  perr  <= s2 ^ (^shift);
                  state <= STOP;
               end
            end
`endif
            STOP: begin
               if (at_last) begin
                  cnt <= '0;
                  if (!s2) begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end else begin
                     state <= IDLE;
`ifdef UART_RX_PARITY_EN
                     parity_err <= perr;
`endif
                  end
               end
            end
            WAIT_IDLE: begin
               cnt <= '0;
               if (s2) state <= IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign io_frameErr = frame_err;
   assign io_rx_valid = !empty;
   assign pop         = io_rx_valid && io_rx_ready;

   // set beats clear when both land in the same cycle
   always_ff @(posedge io_clock) begin
      if (!io_reset) begin
         io_overrun <= 1'b0;
      end else if (push && full && !pop) begin
         io_overrun <= 1'b1;
      end else if (io_clearErr) begin
         io_overrun <= 1'b0;
      end
   end

   uart_rx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk       (io_clock),
      .rst_n     (io_reset),
      .push      (push),
      .push_data (shift),
      .pop       (pop),
      .pop_data  (io_rx_payload),
      .full      (full),
      .empty     (empty)
   );

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Scoreboard bench for uart_rx_monitor at 10 clocks per bit.
// Honours UART_RX_PARITY_EN for 8E1 framing.
module tb_uart_rx_monitor;

   localparam int CLK_FREQ = 100000000;
   localparam int BAUD     = 10000000;
   localparam int DEPTH    = 4;
   localparam int CPB      = CLK_FREQ / BAUD;

   logic       io_clock = 1'b0;
   logic       io_reset;
   logic       io_rxd;
   logic       io_rx_valid;
   logic       io_rx_ready;
   logic [7:0] io_rx_payload;
   logic       io_frameErr;
   logic       io_parityErr;
   logic       io_overrun;
   logic       io_clearErr;

   int n_checks = 0;
   int n_fail   = 0;
   int frame_cnt = 0;
   int par_cnt   = 0;
   int exp_frame = 0;
   int exp_par   = 0;
   logic exp_overrun = 1'b0;
   int rdy_mode = 1;
   logic [7:0] sb[$];

   always #5 io_clock = ~io_clock;

   uart_rx_monitor #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .DEPTH    (DEPTH)
   ) dut (
      .io_clock      (io_clock),
      .io_reset      (io_reset),
      .io_rxd        (io_rxd),
      .io_rx_valid   (io_rx_valid),
      .io_rx_ready   (io_rx_ready),
      .io_rx_payload (io_rx_payload),
      .io_frameErr   (io_frameErr),
      .io_parityErr  (io_parityErr),
      .io_overrun    (io_overrun),
      .io_clearErr   (io_clearErr)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      io_rx_ready = 1'b1;
      forever begin
         @(posedge io_clock);
         #1;
         case (rdy_mode)
            0:       io_rx_ready = 1'b0;
            1:       io_rx_ready = 1'b1;
            default: io_rx_ready = ($urandom_range(3) != 0);
         endcase
      end
   end

   always @(negedge io_clock) begin
      if (io_reset) begin
         if (io_frameErr)  frame_cnt++;
         if (io_parityErr) par_cnt++;
         if (io_rx_valid && io_rx_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_byte", 32'(io_rx_payload), 32'hFFFF_FFFF);
            end else begin
               check("payload", 32'(io_rx_payload), 32'(sb.pop_front()));
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge io_clock);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      io_rxd = b;
      cycles(CPB);
   endtask

   task automatic send(input logic [7:0] d, input logic stop,
                       input logic flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ flip);
      if (!stop) exp_frame++;
      else if (flip) exp_par++;
`else
      if (!stop) exp_frame++;
`endif
`ifdef UART_RX_PARITY_EN
      else if (rdy_mode == 0 && sb.size() >= DEPTH) exp_overrun = 1'b1;
`else
      else if (rdy_mode == 0 && sb.size() >= DEPTH) exp_overrun = 1'b1;
`endif
      else sb.push_back(d);
      drive_bit(stop);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 3000 && sb.size() != 0; i++) cycles(1);
      check(name, 32'(sb.size()), 32'd0);
      cycles(2 * CPB);
   endtask

   task automatic flags(input string name);
      check({name, "_frame"}, 32'(frame_cnt), 32'(exp_frame));
      check({name, "_parity"}, 32'(par_cnt), 32'(exp_par));
      check({name, "_overrun"}, 32'(io_overrun), 32'(exp_overrun));
   endtask

   initial begin
      logic [7:0] ok_str [3];
      ok_str = '{8'h4F, 8'h4B, 8'h0A};
      io_reset    = 1'b0;
      io_rxd      = 1'b1;
      io_clearErr = 1'b0;
      cycles(5);
      io_reset = 1'b1;
      cycles(1);
      check("rst_valid", 32'(io_rx_valid), 32'd0);
      check("rst_payload", 32'(io_rx_payload), 32'd0);
      check("rst_frame", 32'(io_frameErr), 32'd0);
      check("rst_parity", 32'(io_parityErr), 32'd0);
      check("rst_overrun", 32'(io_overrun), 32'd0);
      cycles(3);

      send(8'h55, 1'b1, 1'b0);
      drive_bit(1'b1);
      drain("single_drain");
      flags("single");

      foreach (ok_str[i]) send(ok_str[i], 1'b1, 1'b0);
      drive_bit(1'b1);
      drain("ok_drain");
      flags("ok");

      rdy_mode = 0;
      cycles(2);
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0);
      cycles(3);
      check("ovr_set", 32'(io_overrun), 32'(exp_overrun));
      check("ovr_valid", 32'(io_rx_valid), 32'd1);
      check("ovr_head", 32'(io_rx_payload), 32'h01);
      io_clearErr = 1'b1;
      cycles(1);
      io_clearErr = 1'b0;
      exp_overrun = 1'b0;
      check("ovr_clear", 32'(io_overrun), 32'd0);
      rdy_mode = 1;
      drain("ovr_drain");

      send(8'hA5, 1'b0, 1'b0);
      io_rxd = 1'b0;
      cycles(30);
      io_rxd = 1'b1;
      cycles(2 * CPB);
      check("break_frame", 32'(frame_cnt), 32'(exp_frame));
      send(8'h3C, 1'b1, 1'b0);
      drive_bit(1'b1);
      drain("break_drain");
      flags("break");

      io_rxd = 1'b0;
      cycles(3);
      io_rxd = 1'b1;
      cycles(3 * CPB);
      check("glitch_valid", 32'(io_rx_valid), 32'd0);
      send(8'h5A, 1'b1, 1'b0);
      drive_bit(1'b1);
      drain("glitch_drain");

      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      cycles(3);
      io_reset = 1'b0;
      cycles(2);
      io_reset = 1'b1;
      cycles(5 * CPB);
      check("rstmid_valid", 32'(io_rx_valid), 32'd0);
      flags("rstmid");
      send(8'h81, 1'b1, 1'b0);
      drive_bit(1'b1);
      drain("rstmid_drain");

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1'b1, 1'b0);
      drive_bit(1'b1);
      send(8'h07, 1'b1, 1'b1);
      drive_bit(1'b1);
      drain("par_drain");
      flags("par");
`endif

      rdy_mode = 2;
      for (int n = 0; n < 24; n++) begin
         logic [7:0] d;
         logic st;
         logic fl;
         int gap;
         d   = 8'($urandom);
         st  = ($urandom_range(7) != 0);
         fl  = ($urandom_range(5) == 0);
         gap = st ? int'($urandom_range(2)) : 1 + int'($urandom_range(1));
         send(d, st, fl);
         repeat (gap) drive_bit(1'b1);
      end
      drive_bit(1'b1);
      rdy_mode = 1;
      drain("rand_drain");
      flags("rand");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
